rca_wb_collector: RTL and testbench
===================================

Name: rca_wb_collector

Overview:
- Downstream stage of the RCA grid. Consumes the per-row IO-unit result FIFOs (io_unit_data_out / io_unit_data_valid_out) and drains them into a single register-file writeback port, one word per cycle.
- Drives io_fifo_pop and io_units_rst back to the grid.
- Reports completion of each RCA instruction, tagged with its instruction id, to the issue logic.

Parameters:
- XLEN, 32, datapath width
- GRID_NUM_ROWS, 4, number of IO-unit rows
- ID_WIDTH, 3, instruction id width
- TIMEOUT_CYCLES, 256, watchdog limit (only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  new RCA instruction to collect
- issue_ready  out  1  collector idle, can accept issue
- issue_id  in  ID_WIDTH  instruction id
- issue_row_mask  in  GRID_NUM_ROWS  rows that produce a result
- issue_rd  in  5*GRID_NUM_ROWS  destination register per row (row r at bits [5r+4:5r])
- io_unit_data_out  in  XLEN x GRID_NUM_ROWS  IO-unit FIFO heads
- io_unit_data_valid_out  in  GRID_NUM_ROWS  FIFO head valid
- io_fifo_pop  out  GRID_NUM_ROWS  pop one entry from row FIFO
- io_units_rst  out  1  flush all IO FIFOs
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback accepted
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  writeback data
- done_valid  out  1  instruction complete (one-cycle pulse)
- done_id  out  ID_WIDTH  completed instruction id
- done_err  out  1  completion was a timeout abort

Behaviour:
- Reset (rst=0, async): state=IDLE, pending=0, lock=0.
  - Outputs at reset: issue_ready=1; wb_valid, io_fifo_pop, io_units_rst, done_valid and done_err all 0; done_id=0.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - issue_ready=1.
  - On issue_valid: latch id, rd vector, and pending=issue_row_mask.
  - Next state is COLLECT, or DONE if the mask is 0.
- COLLECT, selection:
  - issue_ready=0.
  - When lock=0, select the lowest-index row r with pending[r] & io_unit_data_valid_out[r].
  - Register that row into sel and set lock=1. wb_valid rises the cycle after lock is set (1-cycle selection latency).
- COLLECT, writeback (lock=1, rd[sel]!=0):
  - wb_valid=1, wb_rd=rd[sel], wb_data=io_unit_data_out[sel].
  - Selection is held stable until wb_ready. A lower-index row becoming valid meanwhile must not change sel.
- COLLECT, handshake:
  - On wb_valid & wb_ready: io_fifo_pop[sel]=1 in the same cycle, clear pending[sel], set lock=0.
- COLLECT, rd[sel]==0:
  - No writeback (wb_valid stays 0).
  - io_fifo_pop[sel] pulses one cycle after lock, then pending[sel] clears and lock=0.
- Pops are one-hot; at most one row is popped per cycle.
- COLLECT exit: when pending==0 and lock==0, go to DONE.
- DONE:
  - Lasts exactly one cycle: done_valid=1, done_id=latched id, done_err=0, io_units_rst=1.
  - Then return to IDLE.
- Throughput: up to 1 writeback every 2 cycles (select, then handshake).
- issue_valid during COLLECT or DONE is ignored.
- A FIFO valid on a row not in pending is ignored and never popped.
- Reset asserted mid-COLLECT aborts immediately: no done pulse and no pop. The grid is responsible for its own FIFO reset.

Optional Feature:
- Macro: RCA_WB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering COLLECT and on every pop, and increments on every other COLLECT cycle.
  - On reaching TIMEOUT_CYCLES-1: go to DONE with done_err=1, pending cleared, wb_valid dropped.
  - io_units_rst still pulses.
- Disabled: no counter, done_err is tied 0, and COLLECT waits indefinitely.

Test Plan:
- Issue id=5, mask=4'b0101, rd0=3, rd2=7; rows 0 and 2 valid with 0xA, 0xB; wb_ready=1:
  - Writebacks (3,0xA) then (7,0xB).
  - Pops on rows 0 then 2.
  - done_valid with done_id=5, and io_units_rst for one cycle.
- Mask=4'b0010, row1 valid, wb_ready held 0 for 4 cycles while row0 becomes valid:
  - wb_rd and wb_data stay on row1 throughout.
  - Row0 is never popped.
  - Pop occurs on the cycle wb_ready=1.
- Mask=4'b1000, rd3=0, row3 valid:
  - No wb_valid.
  - io_fifo_pop[3] pulses once, then done_valid.
- Issue with mask=0: done_valid one cycle after issue, with no pops or writebacks.
- rst low mid-COLLECT (after 1 of 2 writebacks):
  - All outputs return to reset values asynchronously and issue_ready=1.
  - No done_valid.
- With RCA_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, mask=4'b0001, row0 never valid:
  - done_valid=1, done_err=1 at cycle 16 after entering COLLECT.
  - io_units_rst=1.

Source files
------------

// File: rtl/rca_wb_if.sv
// Writeback port between the RCA collector and the register file.
//   wb_valid : collector has a word for the register file
//   wb_ready : register file accepts the word this cycle
//   wb_rd    : destination register
//   wb_data  : writeback data
// master = collector side, slave = register-file side.
interface rca_wb_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/rca_wb_collector.sv
// Drains the per-row IO-unit result FIFOs of the RCA grid into one
// register-file writeback port, one word at a time, then reports
// completion of the instruction to the issue logic.
//
// Ports:
//   clk, rst (async, active low)
//   issue_valid/issue_ready/issue_id/issue_row_mask/issue_rd : new instruction
//   io_unit_data_out/io_unit_data_valid_out : FIFO heads per row
//   io_fifo_pop (one-hot), io_units_rst     : back to the grid
//   wb (rca_wb_if.master)                   : writeback port
//   done_valid/done_id/done_err             : completion pulse
//
// Optional build macro RCA_WB_TIMEOUT_EN adds a watchdog: COLLECT is
// aborted after TIMEOUT_CYCLES cycles without a pop, reported with done_err.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for issue_valid, issue_ready=1
// S_COLLECT | selecting rows (lock=0) and writing/popping them (lock=1)
// S_DONE    | one cycle: done pulse and IO FIFO flush
module rca_wb_collector #(
  parameter int XLEN           = 32,
  parameter int GRID_NUM_ROWS  = 4,
  parameter int ID_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                issue_valid,
  output logic                                issue_ready,
  input  logic [ID_WIDTH-1:0]                 issue_id,
  input  logic [GRID_NUM_ROWS-1:0]            issue_row_mask,
  input  logic [5*GRID_NUM_ROWS-1:0]          issue_rd,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]  io_unit_data_out,
  input  logic [GRID_NUM_ROWS-1:0]            io_unit_data_valid_out,
  output logic [GRID_NUM_ROWS-1:0]            io_fifo_pop,
  output logic                                io_units_rst,
  rca_wb_if.master                            wb,
  output logic                                done_valid,
  output logic [ID_WIDTH-1:0]                 done_id,
  output logic                                done_err
);

  localparam int SEL_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rca_wb_collector: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

  state_e                     state_q;
  logic [GRID_NUM_ROWS-1:0]   pending_q;
  logic                       lock_q;
  logic [SEL_W-1:0]           sel_q;
  logic [ID_WIDTH-1:0]        id_q;
  logic [5*GRID_NUM_ROWS-1:0] rd_q;

  logic [GRID_NUM_ROWS-1:0]   cand;
  logic [SEL_W-1:0]           cand_idx;
  logic                       has_cand;
  logic                       collect;
  logic                       done;
  logic [4:0]                 sel_rd;
  logic                       pop_fire;
  logic                       tmo_hit;

  // Lowest-index pending row whose FIFO head is valid.
  always_comb begin
    cand     = pending_q & io_unit_data_valid_out;
    cand_idx = '0;
    for (int r = GRID_NUM_ROWS - 1; r >= 0; r--) begin
      if (cand[r]) cand_idx = SEL_W'(r);
    end
  end
  assign has_cand = |cand;

  assign collect = (state_q == S_COLLECT);
  assign done    = (state_q == S_DONE);
  assign sel_rd  = rd_q[5*sel_q +: 5];

  // Writes to x0 are dropped: the entry is popped without a writeback.
  assign wb.wb_valid = collect & lock_q & (sel_rd != 5'd0);
  assign wb.wb_rd    = sel_rd;
  assign wb.wb_data  = io_unit_data_out[sel_q];
  assign pop_fire    = collect & lock_q & ((sel_rd == 5'd0) | wb.wb_ready);
  assign io_fifo_pop = GRID_NUM_ROWS'(pop_fire) << sel_q;

  assign issue_ready  = (state_q == S_IDLE);
  assign io_units_rst = done;
  assign done_valid   = done;
  assign done_id      = done ? id_q : '0;

`ifdef RCA_WB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  // A pop in the same cycle as the limit counts as progress, not a timeout.
  assign tmo_hit  = collect & ~pop_fire & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign done_err = done & err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (!collect || pop_fire) tmo_cnt_q <= '0;
      else                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
      // err_q holds through DONE; mask=0 issues pass IDLE and clear it.
      if (!done) err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign done_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      lock_q    <= 1'b0;
      sel_q     <= '0;
      id_q      <= '0;
      rd_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            id_q      <= issue_id;
            rd_q      <= issue_rd;
            pending_q <= issue_row_mask;
            lock_q    <= 1'b0;
            state_q   <= (issue_row_mask == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (tmo_hit) begin
            pending_q <= '0;
            lock_q    <= 1'b0;
            state_q   <= S_DONE;
          end else if (lock_q) begin
            // sel_q stays frozen until the entry is popped.
            if (pop_fire) begin
              pending_q[sel_q] <= 1'b0;
              lock_q           <= 1'b0;
            end
          end else if (has_cand) begin
            sel_q  <= cand_idx;
            lock_q <= 1'b1;
          end else if (pending_q == '0) begin
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_wb_collector.sv
module tb_rca_wb_collector;

`ifdef RCA_WB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        issue_id;
  logic [3:0]        issue_row_mask;
  logic [19:0]       issue_rd;
  logic [3:0][31:0]  io_data;
  logic [3:0]        io_valid;
  logic [3:0]        io_fifo_pop;
  logic              io_units_rst;
  logic              done_valid;
  logic [2:0]        done_id;
  logic              done_err;

  int checks   = 0;
  int failures = 0;

  rca_wb_if #(.XLEN(32)) wb_if ();

  rca_wb_collector #(
    .XLEN(32), .GRID_NUM_ROWS(4), .ID_WIDTH(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .issue_valid            (issue_valid),
    .issue_ready            (issue_ready),
    .issue_id               (issue_id),
    .issue_row_mask         (issue_row_mask),
    .issue_rd               (issue_rd),
    .io_unit_data_out       (io_data),
    .io_unit_data_valid_out (io_valid),
    .io_fifo_pop            (io_fifo_pop),
    .io_units_rst           (io_units_rst),
    .wb                     (wb_if),
    .done_valid             (done_valid),
    .done_id                (done_id),
    .done_err               (done_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, checks 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_wbv"},  64'(wb_if.wb_valid), 64'd0);
    chk({tag, "_pop"},  64'(io_fifo_pop),    64'd0);
    chk({tag, "_iorst"},64'(io_units_rst),   64'd0);
    chk({tag, "_done"}, 64'(done_valid),     64'd0);
    chk({tag, "_err"},  64'(done_err),       64'd0);
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 1'b0; issue_id = '0; issue_row_mask = '0; issue_rd = '0;
    io_data = '0; io_valid = '0;
    wb_if.wb_ready = 1'b0;
    #2;
    // ---------------- reset values
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_id",    64'(done_id),     64'd0);
    idle_outs("rst");
    step(); step();
    rst = 1'b1;

    // ---------------- two writebacks, rows 0 and 2
    step();
    issue_valid = 1'b1; issue_id = 3'd5; issue_row_mask = 4'b0101;
    issue_rd = {5'd0, 5'd7, 5'd0, 5'd3};
    io_data[0] = 32'hA; io_data[2] = 32'hB; io_valid = 4'b0101;
    wb_if.wb_ready = 1'b1;
    #1 chk("t1_ready_idle", 64'(issue_ready), 64'd1);
    step(); issue_valid = 1'b0; #1;          // COLLECT, selecting
    chk("t1_ready_busy", 64'(issue_ready), 64'd0);
    chk("t1_sel_wbv",    64'(wb_if.wb_valid), 64'd0);
    chk("t1_sel_pop",    64'(io_fifo_pop), 64'd0);
    step(); #1;                              // row0 locked
    chk("t1_wb0_v",    64'(wb_if.wb_valid), 64'd1);
    chk("t1_wb0_rd",   64'(wb_if.wb_rd),    64'd3);
    chk("t1_wb0_data", 64'(wb_if.wb_data),  64'hA);
    chk("t1_wb0_pop",  64'(io_fifo_pop),    64'b0001);
    step(); io_valid = 4'b0100; #1;
    chk("t1_sel2_wbv", 64'(wb_if.wb_valid), 64'd0);
    chk("t1_sel2_pop", 64'(io_fifo_pop),    64'd0);
    step(); #1;                              // row2 locked
    chk("t1_wb1_v",    64'(wb_if.wb_valid), 64'd1);
    chk("t1_wb1_rd",   64'(wb_if.wb_rd),    64'd7);
    chk("t1_wb1_data", 64'(wb_if.wb_data),  64'hB);
    chk("t1_wb1_pop",  64'(io_fifo_pop),    64'b0100);
    step(); io_valid = 4'b0000; #1;
    chk("t1_exit_done", 64'(done_valid), 64'd0);
    chk("t1_exit_pop",  64'(io_fifo_pop), 64'd0);
    step(); #1;                              // DONE
    chk("t1_done",     64'(done_valid),   64'd1);
    chk("t1_done_id",  64'(done_id),      64'd5);
    chk("t1_done_err", 64'(done_err),     64'd0);
    chk("t1_iorst",    64'(io_units_rst), 64'd1);
    step(); #1;
    chk("t1_back_ready", 64'(issue_ready), 64'd1);
    idle_outs("t1_back");

    // ---------------- stall on row1, row0 valid must not steal selection
    wb_if.wb_ready = 1'b0;
    issue_valid = 1'b1; issue_id = 3'd2; issue_row_mask = 4'b0010;
    issue_rd = {5'd0, 5'd0, 5'd9, 5'd0};
    io_data[1] = 32'h11; io_valid = 4'b0010;
    step();
    issue_id = 3'd7; issue_row_mask = 4'b0100;   // ignored while busy
    #1;
    step(); io_data[0] = 32'h22; io_valid = 4'b0011; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_v",    64'(wb_if.wb_valid), 64'd1);
      chk("t2_hold_rd",   64'(wb_if.wb_rd),    64'd9);
      chk("t2_hold_data", 64'(wb_if.wb_data),  64'h11);
      chk("t2_hold_pop",  64'(io_fifo_pop),    64'd0);
      step(); #1;
    end
    wb_if.wb_ready = 1'b1; #1;
    chk("t2_pop", 64'(io_fifo_pop), 64'b0010);
    step(); wb_if.wb_ready = 1'b0; io_valid = 4'b0001; issue_valid = 1'b0; #1;
    chk("t2_row0_pop", 64'(io_fifo_pop),    64'd0);
    chk("t2_row0_wbv", 64'(wb_if.wb_valid), 64'd0);
    step(); #1;
    chk("t2_done",     64'(done_valid),  64'd1);
    chk("t2_done_id",  64'(done_id),     64'd2);
    chk("t2_done_pop", 64'(io_fifo_pop), 64'd0);
    step(); io_valid = 4'b0000; #1;

    // ---------------- rd=0 row: pop without writeback
    issue_valid = 1'b1; issue_id = 3'd6; issue_row_mask = 4'b1000;
    issue_rd = {5'd0, 5'd1, 5'd1, 5'd1};
    io_data[3] = 32'h55; io_valid = 4'b1000;
    step(); issue_valid = 1'b0; #1;
    chk("t3_sel_wbv", 64'(wb_if.wb_valid), 64'd0);
    chk("t3_sel_pop", 64'(io_fifo_pop),    64'd0);
    step(); #1;
    chk("t3_lock_wbv", 64'(wb_if.wb_valid), 64'd0);
    chk("t3_lock_pop", 64'(io_fifo_pop),    64'b1000);
    step(); io_valid = 4'b0000; #1;
    chk("t3_after_pop",  64'(io_fifo_pop), 64'd0);
    chk("t3_after_done", 64'(done_valid),  64'd0);
    step(); #1;
    chk("t3_done",    64'(done_valid), 64'd1);
    chk("t3_done_id", 64'(done_id),    64'd6);
    chk("t3_err",     64'(done_err),   64'd0);
    step(); #1;

    // ---------------- empty mask
    issue_valid = 1'b1; issue_id = 3'd1; issue_row_mask = 4'b0000;
    step(); issue_valid = 1'b0; #1;
    chk("t4_done",    64'(done_valid),     64'd1);
    chk("t4_done_id", 64'(done_id),        64'd1);
    chk("t4_iorst",   64'(io_units_rst),   64'd1);
    chk("t4_pop",     64'(io_fifo_pop),    64'd0);
    chk("t4_wbv",     64'(wb_if.wb_valid), 64'd0);
    step(); #1;
    chk("t4_ready", 64'(issue_ready), 64'd1);

    // ---------------- reset during COLLECT after one writeback
    issue_valid = 1'b1; issue_id = 3'd3; issue_row_mask = 4'b0011;
    issue_rd = {5'd0, 5'd0, 5'd5, 5'd4};
    io_data[0] = 32'h33; io_data[1] = 32'h44; io_valid = 4'b0011;
    wb_if.wb_ready = 1'b1;
    step(); issue_valid = 1'b0; #1;
    step(); #1;
    chk("t5_wb0_pop", 64'(io_fifo_pop), 64'b0001);
    step(); io_valid = 4'b0010; #1;
    step(); #1;
    chk("t5_wb1_v", 64'(wb_if.wb_valid), 64'd1);
    rst = 1'b0; #1;
    chk("t5_rst_ready", 64'(issue_ready), 64'd1);
    chk("t5_rst_id",    64'(done_id),     64'd0);
    idle_outs("t5_rst");
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      chk("t5_hold_done", 64'(done_valid),  64'd0);
      chk("t5_hold_pop",  64'(io_fifo_pop), 64'd0);
    end
    rst = 1'b1; io_valid = 4'b0000; wb_if.wb_ready = 1'b0;
    step(); #1;
    chk("t5_post_done",  64'(done_valid),  64'd0);
    chk("t5_post_ready", 64'(issue_ready), 64'd1);

`ifdef RCA_WB_TIMEOUT_EN
    // ---------------- watchdog: row0 never valid
    issue_valid = 1'b1; issue_id = 3'd4; issue_row_mask = 4'b0001;
    issue_rd = {5'd0, 5'd0, 5'd0, 5'd2};
    step(); issue_valid = 1'b0; #1;          // first COLLECT cycle
    chk("t6_start_done", 64'(done_valid), 64'd0);
    for (int i = 1; i < 16; i++) begin
      step(); #1;
      chk("t6_wait_done", 64'(done_valid), 64'd0);
    end
    step(); #1;                              // 16 cycles after entering COLLECT
    chk("t6_done",    64'(done_valid),     64'd1);
    chk("t6_err",     64'(done_err),       64'd1);
    chk("t6_done_id", 64'(done_id),        64'd4);
    chk("t6_iorst",   64'(io_units_rst),   64'd1);
    chk("t6_wbv",     64'(wb_if.wb_valid), 64'd0);
    step(); #1;
    chk("t6_ready", 64'(issue_ready), 64'd1);
    chk("t6_err_clr", 64'(done_err),  64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
